pipe_mem_arbiter: RTL and testbench
===================================

Name: pipe_mem_arbiter

Overview:
Shares one single-port, 32-bit-wide synchronous RAM between the IF-stage fetch port and the MEM-stage load/store port of the 5-stage RV64 pipeline. Sequences doubleword loads and stores as two word beats and steers byte lanes for sub-word stores. Sign- or zero-extends load data according to func3, and flags misaligned accesses. Drives per-stage stall signals so the hazard logic can freeze PC, IF/ID and EX/MEM while an access is in flight.

Parameters:
AW, 8, RAM word-address width (2^AW 32-bit words)
MAX_D_STREAK, 4, consecutive data grants allowed while a fetch waits before the fetch is forced through

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-low reset
if_req  in  1  fetch request; held with if_addr until if_done
if_addr  in  64  fetch byte address (word aligned)
if_done  out  1  1-cycle pulse: if_rdata valid
if_rdata  out  32  fetched instruction
d_req  in  1  data request; held with d_we/d_func3/d_addr/d_wdata until d_done
d_we  in  1  1=store, 0=load
d_func3  in  3  RISC-V load/store func3
d_addr  in  64  data byte address
d_wdata  in  64  store data (right-aligned)
d_done  out  1  1-cycle pulse: access complete (or rejected)
d_rdata  out  64  extended load data, valid with d_done on loads
d_misalign  out  1  pulses with d_done when the access was rejected
stall_if  out  1  if_req & ~if_done
stall_mem  out  1  d_req & ~d_done
mem_en  out  1  RAM enable
mem_we  out  4  RAM byte write enables
mem_addr  out  AW  RAM word address
mem_wdata  out  32  RAM write data
mem_rdata  in  32  RAM read data, valid 1 cycle after an enabled read

Behaviour:
- States: IDLE, IF_RESP, D_LO_RESP, D_HI_RESP, D_WR_HI.
- Reset (reset=0 at a clock edge): state IDLE, streak=0, lo-capture register=0. All outputs are 0 while reset is asserted. An in-flight access is abandoned with no done pulse.
- Word address = addr[AW+1:2]. Upper address bits are ignored.
- IDLE arbitration: data has priority over fetch. The fetch wins instead if streak==MAX_D_STREAK and if_req=1.
- streak increments on each data grant made while if_req=1. It clears on an IF grant, or on a data grant made while if_req=0. It saturates at MAX_D_STREAK.
- Misalignment: half with addr[0]!=0, word with addr[1:0]!=0, or double with addr[2:0]!=0. The access is rejected with no RAM access. d_done=d_misalign=1 in the same IDLE cycle, d_rdata=0, state stays IDLE. A rejection counts as a data grant.
- IF grant: mem_en=1, mem_we=0, then IF_RESP.
- IF_RESP: if_done=1, if_rdata=mem_rdata, then IDLE. No issue this cycle. Fetch throughput is 1 per 2 cycles.
- Load b/h/w/bu/hu/wu: issue a read, then D_LO_RESP. In D_LO_RESP the byte/half lane is selected by addr[1:0] and extended per func3. d_done=1, then IDLE.
- Load d: issue the low word, then D_LO_RESP. Capture the low word, issue a read at word+1, then D_HI_RESP. In D_HI_RESP, d_rdata={mem_rdata, lo}, d_done=1, then IDLE. Latency is 3 cycles.
- Store b: mem_we=4'b0001<<addr[1:0], with the byte replicated on all lanes.
- Store h: mem_we=4'b0011<<addr[1:0], with the half replicated on both halves.
- Store w: mem_we=4'hF.
- Sub-dword stores complete in IDLE: d_done=1 in the issue cycle, state stays IDLE.
- Store d: in IDLE, write the low word with we=F, then D_WR_HI. In D_WR_HI, write wdata[63:32] to word+1, d_done=1, then IDLE.
- Undefined func3 (load 3'b111, store >=3'b100): treated as misaligned and rejected.
- Request drop: a requester that deasserts req mid-access does not cancel it; the done pulse still occurs.
- After a done pulse the requester presents its next request. A request still high in the following IDLE is treated as a new request.
- mem_en=0 and mem_we=0 in every cycle with no issue.
- mem_wdata and d_rdata are don't-care unless qualified, but are driven to 0 when unused.

Test Plan:
- Reset: hold reset=0 for 3 cycles with if_req=d_req=1 -> all outputs 0. After release, the first grant is data.
- Fetch: if_req=1, if_addr=0x10, RAM word 4=0x00500093 -> mem_addr=4 in cycle 0; if_done=1, if_rdata=0x00500093 in cycle 1.
- LD: d_addr=0x20, words 8/9=0x89ABCDEF/0x01234567 -> addresses 8 then 9; d_done in cycle 2 with d_rdata=0x0123456789ABCDEF. LB at 0x23 with word 8 -> 0xFFFFFFFFFFFFFF89; LBU -> 0x89.
- Stores: SH 0xBEEF at 0x22 -> mem_we=4'b1100, mem_wdata=0xBEEFBEEF, d_done same cycle. SD at 0x28 -> two beats to words 10/11, d_done on the second beat.
- Misaligned: LW at 0x21 -> d_done=d_misalign=1, mem_en=0, no state change. SD at 0x2C -> same result.
- Starvation: d_req held high with back-to-back stores and if_req=1 -> exactly 4 data grants, then an IF grant, then data again. stall_if stays high until if_done.

Source files
------------

// File: rtl/pipe_mem_arbiter.sv
// Shares one single-port 32-bit RAM between the IF fetch port and the MEM load/store port.
// Doubleword accesses run as two word beats. Loads are lane-selected and extended.
module pipe_mem_arbiter #(
    parameter int AW           = 8,
    parameter int MAX_D_STREAK = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          if_req,
    input  logic [63:0]   if_addr,
    output logic          if_done,
    output logic [31:0]   if_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [2:0]    d_func3,
    input  logic [63:0]   d_addr,
    input  logic [63:0]   d_wdata,
    output logic          d_done,
    output logic [63:0]   d_rdata,
    output logic          d_misalign,
    output logic          stall_if,
    output logic          stall_mem,
    output logic          mem_en,
    output logic [3:0]    mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata
);

    localparam int SW = $clog2(MAX_D_STREAK + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);

    typedef enum logic [2:0] {IDLE, IF_RESP, D_LO_RESP, D_HI_RESP, D_WR_HI} state_t;

    state_t        state;
    logic [SW-1:0] streak;
    logic [31:0]   lo_p1;
    logic [2:0]    func3_p0;
    logic [1:0]    lane_p0;
    logic [AW-1:0] word_p0;
    logic [31:0]   whi_p0;

    logic [AW-1:0] d_word, if_word;
    logic          fetch_wins, d_grant, i_grant, d_bad, d_is_dbl;
    logic          unused_addr_bits;

    function automatic logic misaligned(input logic we, input logic [2:0] f3, input logic [2:0] a);
        logic bad;
        case (f3[1:0])
            2'd0:    bad = 1'b0;
            2'd1:    bad = a[0];
            2'd2:    bad = |a[1:0];
            default: bad = |a;
        endcase
        // Undefined encodings are rejected exactly like misaligned accesses
        if (we && f3[2])              bad = 1'b1;
        if (!we && (f3 == 3'b111))    bad = 1'b1;
        return bad;
    endfunction

    function automatic logic [63:0] load_ext(input logic [31:0] w, input logic [1:0] lane,
                                             input logic [2:0] f3);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        logic signed [31:0] s;
        logic [63:0]        r;
        b = w[{lane, 3'b000} +: 8];
        h = lane[1] ? w[31:16] : w[15:0];
        s = w;
        case (f3)
            3'b000:  r = 64'(b);
            3'b001:  r = 64'(h);
            3'b010:  r = 64'(s);
            3'b100:  r = {56'd0, w[{lane, 3'b000} +: 8]};
            3'b101:  r = {48'd0, (lane[1] ? w[31:16] : w[15:0])};
            3'b110:  r = {32'd0, w};
            default: r = '0;
        endcase
        return r;
    endfunction

    function automatic logic [3:0] store_we(input logic [1:0] sz, input logic [1:0] lane);
        case (sz)
            2'd0:    return 4'b0001 << lane;
            2'd1:    return 4'b0011 << lane;
            default: return 4'hF;
        endcase
    endfunction

    function automatic logic [31:0] store_data(input logic [1:0] sz, input logic [31:0] w);
        case (sz)
            2'd0:    return {4{w[7:0]}};
            2'd1:    return {2{w[15:0]}};
            default: return w;
        endcase
    endfunction

    function automatic logic [SW-1:0] sat_inc(input logic [SW-1:0] s);
        return (s == STREAK_MAX) ? s : s + SW'(1);
    endfunction

    assign d_word           = d_addr[AW+1:2];
    assign if_word          = if_addr[AW+1:2];
    assign unused_addr_bits = ^{d_addr[63:AW+2], if_addr[63:AW+2], if_addr[1:0]};
    assign fetch_wins       = if_req && (streak == STREAK_MAX);
    assign d_grant          = (state == IDLE) && d_req && !fetch_wins;
    assign i_grant          = (state == IDLE) && if_req && !d_grant;
    assign d_bad            = misaligned(d_we, d_func3, d_addr[2:0]);
    assign d_is_dbl         = (d_func3[1:0] == 2'b11);

    always_comb begin
        if_done    = 1'b0;
        if_rdata   = '0;
        d_done     = 1'b0;
        d_rdata    = '0;
        d_misalign = 1'b0;
        stall_if   = 1'b0;
        stall_mem  = 1'b0;
        mem_en     = 1'b0;
        mem_we     = '0;
        mem_addr   = '0;
        mem_wdata  = '0;
        if (reset) begin
            case (state)
                IDLE: begin
                    if (d_grant) begin
                        if (d_bad) begin
                            d_done     = 1'b1;
                            d_misalign = 1'b1;
                        end else begin
                            mem_en   = 1'b1;
                            mem_addr = d_word;
                            if (d_we) begin
                                mem_we    = store_we(d_func3[1:0], d_addr[1:0]);
                                mem_wdata = store_data(d_func3[1:0], d_wdata[31:0]);
                                d_done    = !d_is_dbl;
                            end
                        end
                    end else if (i_grant) begin
                        mem_en   = 1'b1;
                        mem_addr = if_word;
                    end
                end
                IF_RESP: begin
                    if_done  = 1'b1;
                    if_rdata = mem_rdata;
                end
                D_LO_RESP: begin
                    if (func3_p0[1:0] == 2'b11) begin
                        mem_en   = 1'b1;
                        mem_addr = word_p0 + AW'(1);
                    end else begin
                        d_done  = 1'b1;
                        d_rdata = load_ext(mem_rdata, lane_p0, func3_p0);
                    end
                end
                D_HI_RESP: begin
                    d_done  = 1'b1;
                    d_rdata = {mem_rdata, lo_p1};
                end
                D_WR_HI: begin
                    mem_en    = 1'b1;
                    mem_we    = 4'hF;
                    mem_addr  = word_p0 + AW'(1);
                    mem_wdata = whi_p0;
                    d_done    = 1'b1;
                end
                default: ;
            endcase
            stall_if  = if_req & ~if_done;
            stall_mem = d_req & ~d_done;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= IDLE;
            streak <= '0;
            lo_p1  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (d_grant) begin
                        streak <= if_req ? sat_inc(streak) : '0;
                        if (!d_bad) begin
                            if (!d_we)         state <= D_LO_RESP;
                            else if (d_is_dbl) state <= D_WR_HI;
                        end
                    end else if (i_grant) begin
                        streak <= '0;
                        state  <= IF_RESP;
                    end
                end
                D_LO_RESP: begin
                    if (func3_p0[1:0] == 2'b11) begin
                        lo_p1 <= mem_rdata;
                        state <= D_HI_RESP;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Request fields captured at grant so a dropped request still completes
    always_ff @(posedge clk) begin
        if (d_grant) begin
            func3_p0 <= d_func3;
            lane_p0  <= d_addr[1:0];
            word_p0  <= d_word;
            whi_p0   <= d_wdata[63:32];
        end
    end

endmodule

// File: tb/tb_pipe_mem_arbiter.sv
// Directed bench for pipe_mem_arbiter with a behavioural synchronous RAM.
module tb_pipe_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req;
    logic [63:0] if_addr;
    logic        if_done;
    logic [31:0] if_rdata;
    logic        d_req;
    logic        d_we;
    logic [2:0]  d_func3;
    logic [63:0] d_addr;
    logic [63:0] d_wdata;
    logic        d_done;
    logic [63:0] d_rdata;
    logic        d_misalign;
    logic        stall_if;
    logic        stall_mem;
    logic        mem_en;
    logic [3:0]  mem_we;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] ram [0:255];
    int          n_tests = 0;
    int          n_fail  = 0;

    pipe_mem_arbiter #(.AW(8), .MAX_D_STREAK(4)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_func3(d_func3), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_done(d_done), .d_rdata(d_rdata), .d_misalign(d_misalign),
        .stall_if(stall_if), .stall_mem(stall_mem),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_en) begin
            for (int b = 0; b < 4; b++)
                if (mem_we[b]) ram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
            mem_rdata <= ram[mem_addr];
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // {if_done, d_done, d_misalign, stall_if, stall_mem, mem_en, mem_we}
    function automatic logic [63:0] ctl();
        return 64'({if_done, d_done, d_misalign, stall_if, stall_mem, mem_en, mem_we});
    endfunction

    task automatic set_d(input logic req, input logic we, input logic [2:0] f3,
                         input logic [63:0] a, input logic [63:0] wd);
        d_req = req; d_we = we; d_func3 = f3; d_addr = a; d_wdata = wd;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ram[i] = 32'h0;
        ram[4] = 32'h00500093;
        ram[8] = 32'h89ABCDEF;
        ram[9] = 32'h01234567;
        mem_rdata = '0;
        reset  = 1'b0;
        if_req = 1'b1;
        if_addr = 64'h10;
        set_d(1'b1, 1'b0, 3'b010, 64'h20, 64'h0);

        for (int i = 0; i < 3; i++) begin
            cyc(); #2;
            check("rst_ctl", ctl(), 64'h0);
            check("rst_addr", 64'(mem_addr), 64'h0);
            check("rst_rdata", d_rdata, 64'h0);
            check("rst_wd", {if_rdata, mem_wdata}, 64'h0);
        end

        // first grant after reset goes to data (LW 0x20)
        cyc(); reset = 1'b1; #2;
        check("first_grant_ctl", ctl(), 64'b0001110000);
        check("first_grant_addr", 64'(mem_addr), 64'd8);
        cyc(); #2;
        check("lw_done", ctl(), 64'b0101000000);
        check("lw_data", d_rdata, 64'hFFFFFFFF89ABCDEF);

        // fetch
        cyc(); d_req = 1'b0; #2;
        check("if_issue_ctl", ctl(), 64'b0001010000);
        check("if_issue_addr", 64'(mem_addr), 64'd4);
        cyc(); #2;
        check("if_done_ctl", ctl(), 64'b1000000000);
        check("if_rdata", 64'(if_rdata), 64'h00500093);

        // LD 0x20
        cyc(); if_req = 1'b0; set_d(1'b1, 1'b0, 3'b011, 64'h20, 64'h0); #2;
        check("ld_lo_addr", 64'({mem_en, mem_addr}), 64'h108);
        cyc(); #2;
        check("ld_hi_addr", 64'({mem_en, d_done, mem_addr}), 64'h209);
        cyc(); #2;
        check("ld_done", 64'({d_done, mem_en}), 64'b10);
        check("ld_data", d_rdata, 64'h0123456789ABCDEF);

        // LB / LBU at 0x23
        cyc(); set_d(1'b1, 1'b0, 3'b000, 64'h23, 64'h0); #2;
        cyc(); #2;
        check("lb_data", d_rdata, 64'hFFFFFFFFFFFFFF89);
        cyc(); set_d(1'b1, 1'b0, 3'b100, 64'h23, 64'h0); #2;
        cyc(); #2;
        check("lbu_data", d_rdata, 64'h89);

        // SH 0xBEEF at 0x22
        cyc(); set_d(1'b1, 1'b1, 3'b001, 64'h22, 64'hBEEF); #2;
        check("sh_ctl", ctl(), 64'b0100011100);
        check("sh_addr", 64'(mem_addr), 64'd8);
        check("sh_wdata", 64'(mem_wdata), 64'hBEEFBEEF);

        // SD at 0x28
        cyc(); set_d(1'b1, 1'b1, 3'b011, 64'h28, 64'h1122334455667788); #2;
        check("sd_lo_ctl", ctl(), 64'b0000111111);
        check("sd_lo_aw", {24'd0, mem_addr, mem_wdata}, {24'd0, 8'd10, 32'h55667788});
        cyc(); #2;
        check("sd_hi_ctl", ctl(), 64'b0100011111);
        check("sd_hi_aw", {24'd0, mem_addr, mem_wdata}, {24'd0, 8'd11, 32'h11223344});

        // read back the stores
        cyc(); set_d(1'b1, 1'b0, 3'b011, 64'h28, 64'h0); #2;
        cyc(); #2;
        cyc(); #2;
        check("sd_readback", d_rdata, 64'h1122334455667788);
        cyc(); set_d(1'b1, 1'b0, 3'b010, 64'h20, 64'h0); #2;
        cyc(); #2;
        check("sh_readback", d_rdata, 64'hFFFFFFFFBEEFCDEF);

        // misaligned / undefined accesses rejected in IDLE
        cyc(); set_d(1'b1, 1'b0, 3'b010, 64'h21, 64'h0); #2;
        check("lw_mis_ctl", ctl(), 64'b0110000000);
        check("lw_mis_rdata", d_rdata, 64'h0);
        cyc(); d_req = 1'b0; #2;
        check("lw_mis_idle", ctl(), 64'h0);
        cyc(); set_d(1'b1, 1'b1, 3'b011, 64'h2C, 64'h55); #2;
        check("sd_mis_ctl", ctl(), 64'b0110000000);
        cyc(); d_req = 1'b0; #2;
        check("sd_mis_idle", ctl(), 64'h0);
        cyc(); set_d(1'b1, 1'b1, 3'b100, 64'h30, 64'h55); #2;
        check("bad_f3_ctl", ctl(), 64'b0110000000);

        // starvation: back-to-back SW with a waiting fetch
        cyc(); if_req = 1'b1; if_addr = 64'h10; set_d(1'b1, 1'b1, 3'b010, 64'h30, 64'hCAFE); #2;
        check("starve_d0", ctl(), 64'b0101011111);
        for (int i = 1; i < 4; i++) begin
            cyc(); #2;
            check($sformatf("starve_d%0d", i), ctl(), 64'b0101011111);
        end
        cyc(); #2;
        check("starve_if_ctl", ctl(), 64'b0001110000);
        check("starve_if_addr", 64'(mem_addr), 64'd4);
        cyc(); #2;
        check("starve_if_done", ctl(), 64'b1000100000);
        check("starve_if_rdata", 64'(if_rdata), 64'h00500093);
        cyc(); if_req = 1'b0; #2;
        check("starve_d_again", ctl(), 64'b0100011111);

        cyc(); d_req = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
